// File: rtl/kypd_if.sv
// Keypad pins plus the committed-key event outputs of the scanner.
// The scanner owns the master side; the keypad and consumer logic sit on the slave side.
interface kypd_if;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       key_up;

    modport master (
        input  ROW,
        output COL, key_code, key_valid, key_down, key_up
    );

    modport slave (
        output ROW,
        input  COL, key_code, key_valid, key_down, key_up
    );
endinterface

// File: rtl/kypd_scanner.sv
// 4x4 keypad scanner: column strobe, 2-flop row sync, per-scan ghost rejection, scan-count debounce.
// A stable press commits after DEBOUNCE_SCANS*4*DWELL_CYCLES cycles; there is no backpressure, and events are single-cycle pulses.
module kypd_scanner #(
    parameter int CLOCK_FREQ     = 100000000,
    parameter int DWELL_CYCLES   = CLOCK_FREQ / 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic  clk,
    input  logic  resetn,
    kypd_if.master kp
);
    localparam int         DW = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    logic [3:0]    sync1_q, sync2_q;
    logic          run_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_key_q, acc_key_d;
    logic          cand_vld_q, cand_vld_d;
    logic [3:0]    cand_key_q, cand_key_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          down_q, down_d;
    logic          valid_q, valid_d;
    logic          up_q, up_d;

    logic          sample;
    logic [2:0]    col_hits;
    logic [3:0]    hit_key;
    logic [1:0]    base_cnt;
    logic [3:0]    base_key;
    logic [2:0]    sum_cnt;
    logic          res_vld;
    logic          match;
    logic          commit;

    function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;  4'b11_01: k = 4'hF;  4'b11_10: k = 4'hE;  default:  k = 4'hD;
        endcase
        return k;
    endfunction

    always_comb begin
        dwell_d    = dwell_q;
        col_d      = col_q;
        acc_cnt_d  = acc_cnt_q;
        acc_key_d  = acc_key_q;
        cand_vld_d = cand_vld_q;
        cand_key_d = cand_key_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        down_d     = down_q;
        valid_d    = 1'b0;
        up_d       = 1'b0;
        col_hits   = 3'd0;
        hit_key    = 4'h0;
        base_cnt   = 2'd0;
        base_key   = 4'h0;
        sum_cnt    = 3'd0;
        res_vld    = 1'b0;
        match      = 1'b0;
        commit     = 1'b0;

        sample = run_q && (dwell_q == DWELL_LAST);
        if (run_q) begin
            dwell_d = sample ? '0 : dwell_q + DW'(1);
            col_d   = sample ? col_q + 2'd1 : col_q;
        end

        for (int r = 0; r < 4; r++) begin
            if (!sync2_q[r]) begin
                if (col_hits == 3'd0) hit_key = key_at(2'(r), col_q);
                col_hits = col_hits + 3'd1;
            end
        end

        if (sample) begin
            // Accumulated count saturates at 2: anything beyond one hit is a ghost/multi-key.
            base_cnt  = (col_q == 2'd0) ? 2'd0 : acc_cnt_q;
            base_key  = (col_q == 2'd0) ? 4'h0 : acc_key_q;
            sum_cnt   = {1'b0, base_cnt} + col_hits;
            acc_cnt_d = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
            acc_key_d = (base_cnt == 2'd0 && col_hits != 3'd0) ? hit_key : base_key;

            if (col_q == 2'd3) begin
                res_vld = (acc_cnt_d == 2'd1);
                match   = (res_vld == cand_vld_q) && (!res_vld || acc_key_d == cand_key_q);
                if (match) begin
                    cnt_d = (cnt_q == DB) ? DB : cnt_q + 4'd1;
                end else begin
                    cand_vld_d = res_vld;
                    cand_key_d = acc_key_d;
                    cnt_d      = 4'd1;
                end
                commit = (cnt_d == DB) && (!match || cnt_q != DB);
                if (commit) begin
                    if (res_vld) begin
                        if (!down_q || code_q != acc_key_d) begin
                            code_d  = acc_key_d;
                            down_d  = 1'b1;
                            valid_d = 1'b1;
                        end
                    end else if (down_q) begin
                        down_d = 1'b0;
                        up_d   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            run_q      <= 1'b0;
            dwell_q    <= '0;
            col_q      <= 2'd0;
            acc_cnt_q  <= 2'd0;
            acc_key_q  <= 4'h0;
            cand_vld_q <= 1'b0;
            cand_key_q <= 4'h0;
            cnt_q      <= 4'd0;
            code_q     <= 4'h0;
            down_q     <= 1'b0;
            valid_q    <= 1'b0;
            up_q       <= 1'b0;
        end else begin
            sync1_q    <= kp.ROW;
            sync2_q    <= sync1_q;
            run_q      <= 1'b1;
            dwell_q    <= dwell_d;
            col_q      <= col_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_key_q  <= acc_key_d;
            cand_vld_q <= cand_vld_d;
            cand_key_q <= cand_key_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            down_q     <= down_d;
            valid_q    <= valid_d;
            up_q       <= up_d;
        end
    end

    // Columns stay released until the first clocked cycle out of reset.
    assign kp.COL       = run_q ? ~(4'b0001 << col_q) : 4'hF;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_down  = down_q;
    assign kp.key_up    = up_q;
endmodule

// File: doc/kypd_scanner.md
Name: kypd_scanner

Overview:
- Scans a 4x4 matrix keypad (Pmod KYPD style): drives one column low at a time, reads the four active-low row lines, debounces, and reports keypresses as 4-bit hex key codes.
- Input-side counterpart to the board's multiplexed seven-segment output path. Its key_code/key_valid outputs feed the display/value logic in the keyboard top level.

Parameters:
- CLOCK_FREQ, 100000000, clk frequency in Hz.
- DWELL_CYCLES, CLOCK_FREQ/1000, clk cycles each column is driven (1 ms default); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to commit a change; range 1..15.

Ports:
- clk  input  1  clock.
- resetn  input  1  synchronous, active-low reset.
- ROW  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
- COL  output  4  keypad column drive, active-low, at most one bit low.
- key_code  output  4  hex code of the most recently committed key.
- key_valid  output  1  one-cycle pulse when a new key press is committed.
- key_down  output  1  level, high while a committed key is held.
- key_up  output  1  one-cycle pulse when release is committed.

Behaviour:
- Reset (resetn=0 at a clk edge): COL=4'b1111, key_code=0, key_valid=0, key_down=0, key_up=0. Scan index=0, dwell counter=0, debounce candidate=none, count=0, sync flops=4'b1111.
- Reset applied mid-scan or mid-debounce discards all partial state. No pulse is emitted on reset entry or exit.
- ROW passes through a 2-flop synchronizer before use.
- Scan:
  - Column c (0..3) is driven low (COL = ~(1<<c)) for exactly DWELL_CYCLES cycles. Columns go 0,1,2,3, then wrap to 0.
  - The first cycle after reset release drives column 0.
  - Synchronized rows are sampled on the last cycle of each dwell only.
- Key map (row r, column c), low sample = pressed:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Scan result is evaluated at the end of column 3:
  - exactly one pressed position across the 4 columns: result is that key;
  - zero pressed positions: result is none;
  - two or more pressed positions (ghosting/multi-key): result is none.
- Debounce, once per completed scan:
  - result == candidate: count increments, saturating at DEBOUNCE_SCANS.
  - otherwise: candidate <= result, count <= 1.
- Commit happens on the cycle count first reaches DEBOUNCE_SCANS; with DEBOUNCE_SCANS=1 that is every candidate change.
  - Candidate is key K and (key_down=0 or key_code != K): key_code <= K, key_down <= 1, key_valid pulses 1 cycle.
  - Candidate is none and key_down=1: key_down <= 0, key_up pulses 1 cycle; key_code holds its value.
  - Candidate equals the committed state: no output change.
- Direct key change A->B with no stable none in between: commit B as a new press (key_valid pulse, key_code=B, key_down stays 1). No key_up is emitted.
- key_valid and key_up are never high in the same cycle.
- key_code updates in the same cycle key_valid rises.
- Latency: a press stable from the start of scan N commits at the end of scan N+DEBOUNCE_SCANS-1, which is DEBOUNCE_SCANS*4*DWELL_CYCLES cycles.
- Dwell counter and scan index wrap freely; no overflow at any parameter value in range.

Test Plan (DWELL_CYCLES=8, DEBOUNCE_SCANS=3, scan = 32 cycles):
- Reset, then release: COL=1111 during reset, then 1110 for 8 cycles, 1101, 1011, 0111, repeating. All outputs stay 0 with ROW=1111.
- Hold row1 low whenever COL=1101 (key '5') from scan start: key_valid pulses exactly once at end of 3rd scan, key_code=4'h5, key_down=1. No further pulses while held.
- Release '5' (ROW=1111): key_up pulses after 3 clean scans, key_down=0, key_code stays 5.
- Bounce: assert '9' for 2 scans, release 1 scan, assert 3 scans: exactly one key_valid, code 4'h9, committed at end of the 6th scan.
- Press '1' and 'D' together for 5 scans: no key_valid; if '1' was already committed, key_up fires after 3 scans.
- Hold 'A', then switch directly to '0': second key_valid with key_code=4'h0, key_down held 1, no key_up. Asserting resetn=0 mid-scan then clears all outputs and restarts at column 0.
